pipelined_sum_tree: RTL and testbench

PIPELINED_SUM_TREE -- requirements
Module: pipelined_sum_tree

---
 rtl/dsp_pkg.sv | 39 +++
 rtl/pipelined_sum_tree_if.sv | 33 +++
 rtl/sum_tree_level.sv | 86 ++++++++
 rtl/pipelined_sum_tree.sv | 75 +++++++
 tb/tb_pipelined_sum_tree.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_pkg.sv
// Shared helpers for the pipelined adder tree: level count, per-level
// element counts and per-level operand widths.
package dsp_pkg;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result++;
      end
      return result;
   endfunction

   // Number of registered levels; a single element still gets one register.
   function automatic int tree_levels(input int size);
      return (size <= 1) ? 1 : clog2(size);
   endfunction

   // Elements entering level n: ceil(size / 2^n).
   function automatic int level_count(input int size, input int level);
      return (size + (1 << level) - 1) >> level;
   endfunction

   // Element width entering level n (level = LEVELS gives the output width).
   // With growth each level adds one bit, capped at clog2(size) in total.
   function automatic int level_width(input int width, input int size,
                                      input int grow, input int level);
      int bits;
      bits = (level < clog2(size)) ? level : clog2(size);
      return (grow != 0) ? width + bits : width;
   endfunction

   // Width of the final sum.
   function automatic int owidth(input int width, input int size, input int grow);
      return level_width(width, size, grow, tree_levels(size));
   endfunction

endpackage

// File: rtl/pipelined_sum_tree_if.sv
// AXI-Stream style input and output channels of the sum tree.
interface pipelined_sum_tree_if
   import dsp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SIZE  = 5,
   parameter int GROW  = 1
) ();

   localparam int OWIDTH = owidth(WIDTH, SIZE, GROW);

   logic [SIZE*WIDTH-1:0] i_tdata;
   logic                  i_tvalid;
   logic                  i_tready;
   logic                  i_tlast;
   logic [OWIDTH-1:0]     o_tdata;
   logic                  o_tvalid;
   logic                  o_tready;
   logic                  o_tlast;

   // Upstream producer / downstream consumer side.
   modport master (
      output i_tdata, i_tvalid, i_tlast, o_tready,
      input  i_tready, o_tdata, o_tvalid, o_tlast
   );

   // The sum tree itself.
   modport slave (
      input  i_tdata, i_tvalid, i_tlast, o_tready,
      output i_tready, o_tdata, o_tvalid, o_tlast
   );

endinterface

// File: rtl/sum_tree_level.sv
// One registered level of the adder tree: adds element pairs (2j, 2j+1),
// forwards an odd trailing element unchanged, and holds its own valid/tlast.
module sum_tree_level #(
   parameter int IN_COUNT  = 5,
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 17,
   parameter int SIGNED    = 0
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic                                  clear,
   input  logic [IN_COUNT*IN_WIDTH-1:0]          in_data,
   input  logic                                  in_valid,
   input  logic                                  in_last,
   input  logic                                  next_load,
   output logic                                  load,
   output logic [((IN_COUNT+1)/2)*OUT_WIDTH-1:0] out_data,
   output logic                                  out_valid,
   output logic                                  out_last
);

   localparam int OUT_COUNT = (IN_COUNT + 1) / 2;

   logic [OUT_COUNT*OUT_WIDTH-1:0] sum_next;
   logic [OUT_COUNT*OUT_WIDTH-1:0] data_reg;
   logic                           valid_reg;
   logic                           last_reg;

   // A level may take new data when it is empty or its contents move on.
   assign load = ~valid_reg | next_load;

   for (genvar gi = 0; gi < OUT_COUNT; gi++) begin : g_pair
      logic [IN_WIDTH-1:0]  a_raw;
      logic [OUT_WIDTH-1:0] a_ext;

      assign a_raw = in_data[2*gi*IN_WIDTH +: IN_WIDTH];

      if (SIGNED != 0) begin : g_a_ext
         assign a_ext = OUT_WIDTH'($signed(a_raw));
      end else begin : g_a_ext
         assign a_ext = OUT_WIDTH'(a_raw);
      end

      if (2*gi + 1 < IN_COUNT) begin : g_op
         logic [IN_WIDTH-1:0]  b_raw;
         logic [OUT_WIDTH-1:0] b_ext;

         assign b_raw = in_data[(2*gi+1)*IN_WIDTH +: IN_WIDTH];
         if (SIGNED != 0) begin : g_b_ext
            assign b_ext = OUT_WIDTH'($signed(b_raw));
         end else begin : g_b_ext
            assign b_ext = OUT_WIDTH'(b_raw);
         end
         assign sum_next[gi*OUT_WIDTH +: OUT_WIDTH] = a_ext + b_ext;
      end else begin : g_op
         assign sum_next[gi*OUT_WIDTH +: OUT_WIDTH] = a_ext;
      end
   end

   // Occupancy: follows the upstream valid on each load, emptied by clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_reg <= 1'b0;
      end else if (clear) begin
         valid_reg <= 1'b0;
      end else if (load) begin
         valid_reg <= in_valid;
      end
   end

   // Payload: captured only on a real transfer so a held level stays put.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_reg <= '0;
         last_reg <= 1'b0;
      end else if (load && in_valid && !clear) begin
         data_reg <= sum_next;
         last_reg <= in_last;
      end
   end

   assign out_data  = data_reg;
   assign out_valid = valid_reg;
   assign out_last  = last_reg;

endmodule

// File: rtl/pipelined_sum_tree.sv
// Pipelined adder tree: sums SIZE elements through clog2(SIZE) registered
// levels with a per-level valid/ready stall chain.
module pipelined_sum_tree
   import dsp_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int SIZE   = 5,
   parameter int SIGNED = 0,
   parameter int GROW   = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clear,
   pipelined_sum_tree_if.slave  bus
);

   localparam int LEVELS = tree_levels(SIZE);

   for (genvar gi = 0; gi < LEVELS; gi++) begin : g_level
      localparam int IN_COUNT  = level_count(SIZE, gi);
      localparam int OUT_COUNT = (IN_COUNT + 1) / 2;
      localparam int IN_WIDTH  = level_width(WIDTH, SIZE, GROW, gi);
      localparam int OUT_WIDTH = level_width(WIDTH, SIZE, GROW, gi + 1);

      logic [IN_COUNT*IN_WIDTH-1:0]   in_data;
      logic                           in_valid;
      logic                           in_last;
      logic                           next_load;
      logic                           load;
      logic [OUT_COUNT*OUT_WIDTH-1:0] out_data;
      logic                           out_valid;
      logic                           out_last;

      if (gi == 0) begin : g_src
         assign in_data  = bus.i_tdata;
         assign in_valid = bus.i_tvalid;
         assign in_last  = bus.i_tlast;
      end else begin : g_src
         assign in_data  = g_level[gi-1].out_data;
         assign in_valid = g_level[gi-1].out_valid;
         assign in_last  = g_level[gi-1].out_last;
      end

      if (gi == LEVELS - 1) begin : g_dst
         assign next_load = bus.o_tready;
      end else begin : g_dst
         assign next_load = g_level[gi+1].load;
      end

      sum_tree_level #(
         .IN_COUNT  (IN_COUNT),
         .IN_WIDTH  (IN_WIDTH),
         .OUT_WIDTH (OUT_WIDTH),
         .SIGNED    (SIGNED)
      ) u_level (
         .clk       (clk),
         .reset_n   (reset_n),
         .clear     (clear),
         .in_data   (in_data),
         .in_valid  (in_valid),
         .in_last   (in_last),
         .next_load (next_load),
         .load      (load),
         .out_data  (out_data),
         .out_valid (out_valid),
         .out_last  (out_last)
      );
   end

   assign bus.i_tready = g_level[0].load;
   assign bus.o_tdata  = g_level[LEVELS-1].out_data;
   assign bus.o_tvalid = g_level[LEVELS-1].out_valid;
   assign bus.o_tlast  = g_level[LEVELS-1].out_last;

endmodule

// File: tb/tb_pipelined_sum_tree.sv
// Directed bench for pipelined_sum_tree: three configurations, a vector
// table, a randomized-handshake ramp, backpressure fill/drain, clear and
// mid-stream reset.
module tb_pipelined_sum_tree;

   localparam int A_LEVELS = 3;

   typedef struct {
      int          dut;   // 0: 5x8 unsigned grow, 1: 4x8 signed grow, 2: 2x8 wrap
      logic [39:0] data;
      logic        last;
      logic [15:0] exp;
      int          lat;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n;
   logic clear;
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   pipelined_sum_tree_if #(.WIDTH(8), .SIZE(5), .GROW(1)) bus_a ();
   pipelined_sum_tree_if #(.WIDTH(8), .SIZE(4), .GROW(1)) bus_b ();
   pipelined_sum_tree_if #(.WIDTH(8), .SIZE(2), .GROW(0)) bus_c ();

   pipelined_sum_tree #(.WIDTH(8), .SIZE(5), .SIGNED(0), .GROW(1)) dut_a (
      .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus_a));
   pipelined_sum_tree #(.WIDTH(8), .SIZE(4), .SIGNED(1), .GROW(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus_b));
   pipelined_sum_tree #(.WIDTH(8), .SIZE(2), .SIGNED(0), .GROW(0)) dut_c (
      .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus_c));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_in(input int dut, input logic [39:0] data, input logic valid,
                           input logic last);
      case (dut)
         0: begin bus_a.i_tdata = data;        bus_a.i_tvalid = valid; bus_a.i_tlast = last; end
         1: begin bus_b.i_tdata = data[31:0];  bus_b.i_tvalid = valid; bus_b.i_tlast = last; end
         default: begin bus_c.i_tdata = data[15:0]; bus_c.i_tvalid = valid; bus_c.i_tlast = last; end
      endcase
   endtask

   function automatic logic get_ovalid(input int dut);
      case (dut)
         0: return bus_a.o_tvalid;
         1: return bus_b.o_tvalid;
         default: return bus_c.o_tvalid;
      endcase
   endfunction

   function automatic logic get_olast(input int dut);
      case (dut)
         0: return bus_a.o_tlast;
         1: return bus_b.o_tlast;
         default: return bus_c.o_tlast;
      endcase
   endfunction

   function automatic logic get_iready(input int dut);
      case (dut)
         0: return bus_a.i_tready;
         1: return bus_b.i_tready;
         default: return bus_c.i_tready;
      endcase
   endfunction

   function automatic logic [15:0] get_odata(input int dut);
      case (dut)
         0: return 16'(bus_a.o_tdata);
         1: return 16'(bus_b.o_tdata);
         default: return 16'(bus_c.o_tdata);
      endcase
   endfunction

   // Ramp element k of transfer i and its reference sum.
   function automatic logic [39:0] ramp_data(input int i);
      logic [39:0] d;
      d = '0;
      for (int k = 0; k < 5; k++) d[k*8 +: 8] = 8'((i*7 + k*40) % 256);
      return d;
   endfunction

   function automatic logic [15:0] ramp_sum(input int i);
      int s;
      s = 0;
      for (int k = 0; k < 5; k++) s += (i*7 + k*40) % 256;
      return 16'(s);
   endfunction

   // One isolated transfer with o_tready held high; checks sum, tlast, latency.
   task automatic send_vec(input int dut, input logic [39:0] data, input logic last,
                           input logic [15:0] exp, input int lat, input string tag);
      int cyc;
      @(negedge clk);
      drive_in(dut, data, 1'b1, last);
      #1 check({tag, " i_tready"}, 64'(get_iready(dut)), 64'd1);
      @(posedge clk);
      @(negedge clk);
      drive_in(dut, '0, 1'b0, 1'b0);
      cyc = 1;
      while (!get_ovalid(dut) && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, " latency"}, 64'(cyc), 64'(lat));
      check({tag, " o_tdata"}, 64'(get_odata(dut)), 64'(exp));
      check({tag, " o_tlast"}, 64'(get_olast(dut)), 64'(last));
      $display("%s: dut=%0d sum=0x%0h last=%0b latency=%0d", tag, dut,
               get_odata(dut), get_olast(dut), cyc);
   endtask

   // Push transfers into configuration A with the output blocked.
   task automatic fill_a(input int cycles, input logic [7:0] elem);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         bus_a.o_tready = 1'b0;
         drive_in(0, {5{elem}}, 1'b1, 1'b0);
      end
      @(negedge clk);
      drive_in(0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[13];
      int   sent, recv, cyc, acc, got;
      logic pending, stalled, held_last, in_hs, hs;
      logic [15:0] held;

      vecs[0]  = '{0, 40'hFFFFFFFFFF, 1'b1, 16'd1275,  3};
      vecs[1]  = '{0, 40'h0000000000, 1'b0, 16'd0,     3};
      vecs[2]  = '{0, 40'h0504030201, 1'b1, 16'd15,    3};
      vecs[3]  = '{0, 40'h00000000FF, 1'b0, 16'd255,   3};
      vecs[4]  = '{0, 40'hFF00000000, 1'b1, 16'd255,   3};
      vecs[5]  = '{0, 40'h32281E140A, 1'b0, 16'd150,   3};
      vecs[6]  = '{1, 40'h00017F8080, 1'b1, 16'h0380,  2};
      vecs[7]  = '{1, 40'h007F7F7F7F, 1'b0, 16'h01FC,  2};
      vecs[8]  = '{1, 40'h00FFFFFFFF, 1'b1, 16'h03FC,  2};
      vecs[9]  = '{1, 40'h0080808080, 1'b0, 16'h0200,  2};
      vecs[10] = '{2, 40'h00000064C8, 1'b1, 16'd44,    1};
      vecs[11] = '{2, 40'h00000001FF, 1'b0, 16'd0,     1};
      vecs[12] = '{2, 40'h0000000907, 1'b1, 16'd16,    1};

      clear = 1'b0;
      for (int d = 0; d < 3; d++) drive_in(d, '0, 1'b0, 1'b0);
      bus_a.o_tready = 1'b1;
      bus_b.o_tready = 1'b1;
      bus_c.o_tready = 1'b1;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;

      // Reset state.
      @(posedge clk);
      @(negedge clk);
      check("reset o_tvalid", 64'(bus_a.o_tvalid), 64'd0);
      check("reset o_tdata",  64'(bus_a.o_tdata),  64'd0);
      check("reset o_tlast",  64'(bus_a.o_tlast),  64'd0);
      check("reset i_tready", 64'(bus_a.i_tready), 64'd1);
      check("reset b o_tvalid", 64'(bus_b.o_tvalid), 64'd0);
      reset_n = 1'b1;

      // Table of isolated transfers.
      for (int v = 0; v < 13; v++) begin
         send_vec(vecs[v].dut, vecs[v].data, vecs[v].last, vecs[v].exp, vecs[v].lat,
                  $sformatf("vec%0d", v));
      end

      // Ramp with random producer and consumer handshakes.
      sent = 0; recv = 0; cyc = 0; pending = 1'b0; stalled = 1'b0;
      held = '0; held_last = 1'b0;
      while (recv < 100 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (!pending && sent < 100) pending = 1'($urandom_range(0, 1));
         drive_in(0, ramp_data(sent), pending, 1'((sent % 4) == 3));
         bus_a.o_tready = 1'($urandom_range(0, 1));
         #1;
         if (stalled) begin
            check("ramp hold o_tvalid", 64'(bus_a.o_tvalid), 64'd1);
            check("ramp hold o_tdata",  64'(bus_a.o_tdata),  64'(held));
            check("ramp hold o_tlast",  64'(bus_a.o_tlast),  64'(held_last));
         end
         if (bus_a.o_tvalid && bus_a.o_tready) begin
            check($sformatf("ramp%0d o_tdata", recv), 64'(bus_a.o_tdata), 64'(ramp_sum(recv)));
            check($sformatf("ramp%0d o_tlast", recv), 64'(bus_a.o_tlast), 64'((recv % 4) == 3));
            $display("ramp%0d: sum=%0d last=%0b", recv, bus_a.o_tdata, bus_a.o_tlast);
            recv++;
         end
         stalled   = bus_a.o_tvalid && !bus_a.o_tready;
         held      = 16'(bus_a.o_tdata);
         held_last = bus_a.o_tlast;
         in_hs     = pending && bus_a.i_tready;
         @(posedge clk);
         if (in_hs) begin
            sent++;
            pending = 1'b0;
         end
      end
      @(negedge clk);
      drive_in(0, '0, 1'b0, 1'b0);
      bus_a.o_tready = 1'b1;
      check("ramp received", 64'(recv), 64'd100);
      check("ramp sent", 64'(sent), 64'd100);
      repeat (5) @(negedge clk);
      check("ramp no extra output", 64'(bus_a.o_tvalid), 64'd0);

      // Backpressure: output blocked for 10 cycles with input always offered.
      acc = 0;
      bus_a.o_tready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         drive_in(0, {5{8'(acc + 1)}}, 1'b1, 1'b0);
         #1 hs = bus_a.i_tready;
         @(posedge clk);
         if (hs) acc++;
         @(negedge clk);
      end
      drive_in(0, {5{8'(acc + 1)}}, 1'b1, 1'b0);
      #1;
      check("stall accepted", 64'(acc), 64'(A_LEVELS));
      check("stall i_tready", 64'(bus_a.i_tready), 64'd0);
      $display("stall: accepted=%0d i_tready=%0b", acc, bus_a.i_tready);
      drive_in(0, '0, 1'b0, 1'b0);
      bus_a.o_tready = 1'b1;
      got = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (bus_a.o_tvalid) begin
            check($sformatf("drain%0d o_tdata", got), 64'(bus_a.o_tdata), 64'(5 * (got + 1)));
            $display("drain%0d: sum=%0d", got, bus_a.o_tdata);
            got++;
         end
         @(negedge clk);
      end
      check("drain count", 64'(got), 64'(A_LEVELS));

      // Clear with a simultaneous input offer.
      fill_a(4, 8'h07);
      bus_a.o_tready = 1'b0;
      clear = 1'b1;
      drive_in(0, {5{8'h11}}, 1'b1, 1'b1);
      @(posedge clk);
      @(negedge clk);
      clear = 1'b0;
      drive_in(0, '0, 1'b0, 1'b0);
      #1;
      check("clear o_tvalid", 64'(bus_a.o_tvalid), 64'd0);
      check("clear i_tready", 64'(bus_a.i_tready), 64'd1);
      $display("clear: o_tvalid=%0b i_tready=%0b", bus_a.o_tvalid, bus_a.i_tready);
      bus_a.o_tready = 1'b1;
      send_vec(0, 40'h0A0A0A0A0A, 1'b1, 16'd50, 3, "post-clear");

      // Asynchronous reset in the middle of a cycle with data in flight.
      fill_a(4, 8'h09);
      #2 reset_n = 1'b0;
      #1;
      check("async reset o_tvalid", 64'(bus_a.o_tvalid), 64'd0);
      check("async reset o_tdata",  64'(bus_a.o_tdata),  64'd0);
      check("async reset i_tready", 64'(bus_a.i_tready), 64'd1);
      $display("reset: o_tvalid=%0b o_tdata=%0d i_tready=%0b",
               bus_a.o_tvalid, bus_a.o_tdata, bus_a.i_tready);
      @(negedge clk);
      reset_n = 1'b1;
      bus_a.o_tready = 1'b1;
      send_vec(0, 40'h0102030405, 1'b0, 16'd15, 3, "post-reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
